rf_operand_fetch: RTL and testbench
===================================

RF_OPERAND_FETCH -- requirements
Module: rf_operand_fetch

Interface
REQ-001 Parameter SB_EN, default 1: 1 = scoreboard hazard checking enabled; 0 = no hazard checks and no stalls.
REQ-002 Parameter STALL_CNT_W, default 16: width of the stall performance counter.
REQ-003 i_clk  in  1  clock; all state changes on rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_clk_en  in  1  clock enable; when 0, all state holds.
REQ-006 i_valid  in  1  decoded instruction valid (upstream).
REQ-007 o_ready  out  1  instruction accepted this cycle when high together with i_valid.
REQ-008 i_rs0, i_rs1  in  4 each  source register addresses.
REQ-009 i_use_rs0, i_use_rs1  in  1 each  source actually read (gates hazard check).
REQ-010 i_rd  in  4  destination register; i_rd_we  in  1  instruction writes i_rd.
REQ-011 o_raddr_0, o_raddr_1  out  4 each  register file read addresses, combinationally equal to i_rs0, i_rs1.
REQ-012 i_rdata_0, i_rdata_1  in  32 each  register file read data (asynchronous, write-bypassed).
REQ-013 i_wb_valid  in  1  write-back retiring this cycle; i_wb_addr  in  4  retiring register.
REQ-014 o_valid  out  1  operand bundle valid (downstream); i_ready  in  1  downstream accepts.
REQ-015 o_op0, o_op1  out  32 each  latched operands; o_rd  out  4; o_rd_we  out  1.
REQ-016 o_stall_cnt  out  STALL_CNT_W  saturating count of hazard-stall cycles.

Function
REQ-017 Output stage is a single register with states EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-018 Hazard = SB_EN && i_valid && ((i_use_rs0 && pend[i_rs0] && !clr0) || (i_use_rs1 && pend[i_rs1] && !clr1)), where clrN = i_wb_valid && i_wb_addr==i_rsN.
REQ-019 The same-cycle write-back clear relies on register file bypass; operands are taken from i_rdata_* unchanged.
REQ-020 o_ready = !hazard && (state==EMPTY || i_ready); o_ready is combinational and does not depend on i_valid except through the hazard term.
REQ-021 Accept (i_valid && o_ready && i_clk_en): o_op0<=i_rdata_0, o_op1<=i_rdata_1, o_rd<=i_rd, o_rd_we<=i_rd_we, state<=FULL.
REQ-022 On FULL && i_ready with no accept, state goes to EMPTY; output data registers hold their last value.
REQ-023 While FULL && !i_ready, o_op0, o_op1, o_rd and o_rd_we stay stable.
REQ-024 Scoreboard pend[15:0]: on accept with i_rd_we, pend[i_rd] is set; on i_wb_valid, pend[i_wb_addr] is cleared.
REQ-025 A set and a clear of the same address in the same cycle leaves the bit set.
REQ-026 i_wb_valid for a non-pending address is ignored; no error is flagged.
REQ-027 o_stall_cnt increments by 1 on each i_clk_en cycle with hazard=1, and saturates at all-ones.
REQ-028 Fetch latency: operands are visible on o_op* one cycle after acceptance.
REQ-029 Throughput: one instruction per cycle when there is no hazard and i_ready stays high.

Reset
REQ-030 While i_rst is high: state=EMPTY, o_valid=0, pend=0, o_op0=o_op1=0, o_rd=0, o_rd_we=0, o_stall_cnt=0.
REQ-031 Reset mid-operation discards the held bundle and all pending bits immediately, without waiting for a clock.
REQ-032 Outputs during reset: o_ready reflects the reset state (high if i_valid has no hazard); no acceptance occurs while i_rst is high.

Verification
REQ-033 Back-to-back independent instructions (rs=1,2; rd=3,4), i_ready=1, RF returns 0x11111111/0x22222222 -> o_valid every cycle from cycle 1, operands match, o_stall_cnt=0.
REQ-034 RAW hazard: instr A rd=5; instr B rs0=5 next cycle; write-back of R5 three cycles later -> o_ready=0 for 3 cycles, B accepted in the cycle i_wb_addr=5, o_stall_cnt=3.
REQ-035 Backpressure: i_ready=0 for 4 cycles with FULL, op0=0xDEADBEEF -> o_ready=0, outputs stable, then release -> next bundle follows one cycle later.
REQ-036 Same-cycle set/clear: accept rd=7 while i_wb_addr=7 -> pend[7] stays 1, and a subsequent reader of R7 stalls.
REQ-037 Async reset asserted mid-stall (pend[5]=1, FULL) -> o_valid=0, pend=0 and o_stall_cnt=0 before the next edge; after release an instruction reading R5 is accepted at once.
REQ-038 Saturation: STALL_CNT_W=4, force 20 stall cycles -> o_stall_cnt holds at 15.

Source files
------------

// File: rtl/rf_operand_fetch_if.sv
// Operand-fetch bundle: upstream decode handshake, register file read port,
// write-back retire notification and downstream operand handshake.
interface rf_operand_fetch_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   i_clk_en;
  logic                   i_valid;
  logic                   o_ready;
  logic [3:0]             i_rs0;
  logic [3:0]             i_rs1;
  logic                   i_use_rs0;
  logic                   i_use_rs1;
  logic [3:0]             i_rd;
  logic                   i_rd_we;
  logic [3:0]             o_raddr_0;
  logic [3:0]             o_raddr_1;
  logic [31:0]            i_rdata_0;
  logic [31:0]            i_rdata_1;
  logic                   i_wb_valid;
  logic [3:0]             i_wb_addr;
  logic                   o_valid;
  logic                   i_ready;
  logic [31:0]            o_op0;
  logic [31:0]            o_op1;
  logic [3:0]             o_rd;
  logic                   o_rd_we;
  logic [STALL_CNT_W-1:0] o_stall_cnt;
  logic [0:0]             o_fsm_state;

  // Both handshakes: a transfer happens on a rising edge where valid and
  // ready are both high; valid never waits on ready, ready may depend on valid.
  modport master (
    output i_clk_en, i_valid, i_rs0, i_rs1, i_use_rs0, i_use_rs1, i_rd, i_rd_we,
           i_rdata_0, i_rdata_1, i_wb_valid, i_wb_addr, i_ready,
    input  o_ready, o_raddr_0, o_raddr_1, o_valid, o_op0, o_op1, o_rd, o_rd_we,
           o_stall_cnt, o_fsm_state
  );

  modport slave (
    input  i_clk_en, i_valid, i_rs0, i_rs1, i_use_rs0, i_use_rs1, i_rd, i_rd_we,
           i_rdata_0, i_rdata_1, i_wb_valid, i_wb_addr, i_ready,
    output o_ready, o_raddr_0, o_raddr_1, o_valid, o_op0, o_op1, o_rd, o_rd_we,
           o_stall_cnt, o_fsm_state
  );
endinterface

// File: rtl/rf_operand_fetch.sv
// Register-file operand fetch stage: scoreboard RAW hazard check, one-entry
// output register and a saturating stall-cycle counter.
module rf_operand_fetch #(
  parameter bit SB_EN       = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input logic               i_clk,
  input logic               i_rst,
  rf_operand_fetch_if.slave bus
);
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]             state;
  logic [15:0]            pend;
  logic [15:0]            pend_nxt;
  logic [31:0]            op0_q;
  logic [31:0]            op1_q;
  logic [3:0]             rd_q;
  logic                   rd_we_q;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   clr0;
  logic                   clr1;
  logic                   hazard;
  logic                   ready;
  logic                   accept;

  // A write-back retiring this cycle is bypassed by the register file, so it
  // already satisfies a reader of that register.
  always_comb begin
    clr0   = bus.i_wb_valid && (bus.i_wb_addr == bus.i_rs0);
    clr1   = bus.i_wb_valid && (bus.i_wb_addr == bus.i_rs1);
    hazard = SB_EN && bus.i_valid &&
             ((bus.i_use_rs0 && pend[bus.i_rs0] && !clr0) ||
              (bus.i_use_rs1 && pend[bus.i_rs1] && !clr1));
    ready  = !hazard && ((state == ST_EMPTY) || bus.i_ready);
    accept = bus.i_valid && ready && bus.i_clk_en;
  end

  // Set after clear so a same-cycle set and clear of one address keeps it pending.
  always_comb begin
    pend_nxt = pend;
    if (bus.i_wb_valid) pend_nxt[bus.i_wb_addr] = 1'b0;
    if (accept && bus.i_rd_we) pend_nxt[bus.i_rd] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_EMPTY;
      pend      <= '0;
      op0_q     <= '0;
      op1_q     <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      stall_cnt <= '0;
    end else if (bus.i_clk_en) begin
      pend <= pend_nxt;
      if (accept) begin
        op0_q   <= bus.i_rdata_0;
        op1_q   <= bus.i_rdata_1;
        rd_q    <= bus.i_rd;
        rd_we_q <= bus.i_rd_we;
        state   <= ST_FULL;
      end else if ((state == ST_FULL) && bus.i_ready) begin
        state <= ST_EMPTY;
      end
      if (hazard && (stall_cnt != '1))
        stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.o_ready     = ready;
  assign bus.o_raddr_0   = bus.i_rs0;
  assign bus.o_raddr_1   = bus.i_rs1;
  assign bus.o_valid     = (state == ST_FULL);
  assign bus.o_op0       = op0_q;
  assign bus.o_op1       = op1_q;
  assign bus.o_rd        = rd_q;
  assign bus.o_rd_we     = rd_we_q;
  assign bus.o_stall_cnt = stall_cnt;
  assign bus.o_fsm_state = state;

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Self-checking bench for rf_operand_fetch: directed hazard/backpressure/reset
// scenarios followed by randomized traffic against a behavioural model.
module tb_rf_operand_fetch;
  logic i_clk;
  logic i_rst;

  rf_operand_fetch_if #(.STALL_CNT_W(16)) bus ();
  rf_operand_fetch_if #(.STALL_CNT_W(4))  bus_s ();

  rf_operand_fetch #(.SB_EN(1'b1), .STALL_CNT_W(16)) u_dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  rf_operand_fetch #(.SB_EN(1'b1), .STALL_CNT_W(4)) u_sat (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus_s)
  );

  // The narrow-counter instance sees exactly the same stimulus.
  assign bus_s.i_clk_en   = bus.i_clk_en;
  assign bus_s.i_valid    = bus.i_valid;
  assign bus_s.i_rs0      = bus.i_rs0;
  assign bus_s.i_rs1      = bus.i_rs1;
  assign bus_s.i_use_rs0  = bus.i_use_rs0;
  assign bus_s.i_use_rs1  = bus.i_use_rs1;
  assign bus_s.i_rd       = bus.i_rd;
  assign bus_s.i_rd_we    = bus.i_rd_we;
  assign bus_s.i_rdata_0  = bus.i_rdata_0;
  assign bus_s.i_rdata_1  = bus.i_rdata_1;
  assign bus_s.i_wb_valid = bus.i_wb_valid;
  assign bus_s.i_wb_addr  = bus.i_wb_addr;
  assign bus_s.i_ready    = bus.i_ready;

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard / model ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];       // operand-0 of every accepted bundle, in order
  bit          m_full;
  logic [31:0] m_op0, m_op1;
  logic [3:0]  m_rd;
  logic        m_rd_we;
  bit [15:0]   m_pend;
  int          m_stalls;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_full = 0; m_op0 = '0; m_op1 = '0; m_rd = '0; m_rd_we = 1'b0;
    m_pend = '0; m_stalls = 0; exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.i_clk_en = 1'b1; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    bus.i_rs0 = '0; bus.i_rs1 = '0; bus.i_use_rs0 = 1'b0; bus.i_use_rs1 = 1'b0;
    bus.i_rd = '0; bus.i_rd_we = 1'b0; bus.i_rdata_0 = '0; bus.i_rdata_1 = '0;
    bus.i_wb_valid = 1'b0; bus.i_wb_addr = '0;
  endtask

  task automatic drive_instr(input logic [3:0] rs0, input bit u0, input logic [3:0] rs1,
                             input bit u1, input logic [3:0] rd, input bit we,
                             input logic [31:0] d0, input logic [31:0] d1);
    bus.i_valid = 1'b1; bus.i_rs0 = rs0; bus.i_use_rs0 = u0; bus.i_rs1 = rs1;
    bus.i_use_rs1 = u1; bus.i_rd = rd; bus.i_rd_we = we;
    bus.i_rdata_0 = d0; bus.i_rdata_1 = d1;
  endtask

  // Called just after a falling edge with inputs already driven; returns at
  // the next falling edge after checking combinational and registered outputs.
  task automatic tick();
    bit hz, rdy, acc, stalled0, stalled1;
    #1;
    stalled0 = bus.i_use_rs0 && m_pend[bus.i_rs0] &&
               !(bus.i_wb_valid && bus.i_wb_addr == bus.i_rs0);
    stalled1 = bus.i_use_rs1 && m_pend[bus.i_rs1] &&
               !(bus.i_wb_valid && bus.i_wb_addr == bus.i_rs1);
    hz  = bus.i_valid && (stalled0 || stalled1);
    rdy = !hz && (!m_full || bus.i_ready);
    check("o_ready", {31'd0, bus.o_ready}, {31'd0, rdy});
    check("o_ready_sat", {31'd0, bus_s.o_ready}, {31'd0, rdy});
    check("o_raddr", {24'd0, bus.o_raddr_1, bus.o_raddr_0}, {24'd0, bus.i_rs1, bus.i_rs0});
    acc = bus.i_valid && rdy && bus.i_clk_en;
    @(posedge i_clk);
    if (bus.i_clk_en && !i_rst) begin
      if (hz) m_stalls++;
      if (m_full && bus.i_ready) begin
        m_full = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (acc) begin
        m_full = 1; m_op0 = bus.i_rdata_0; m_op1 = bus.i_rdata_1;
        m_rd = bus.i_rd; m_rd_we = bus.i_rd_we;
        exp_q.push_back(bus.i_rdata_0);
      end
      if (bus.i_wb_valid) m_pend[bus.i_wb_addr] = 1'b0;
      if (acc && bus.i_rd_we) m_pend[bus.i_rd] = 1'b1;
    end
    @(negedge i_clk);
    check("o_valid", {31'd0, bus.o_valid}, {31'd0, m_full});
    if (m_full && exp_q.size() > 0) check("o_op0_order", bus.o_op0, exp_q[0]);
    check("o_op0", bus.o_op0, m_op0);
    check("o_op1", bus.o_op1, m_op1);
    check("o_rd", {27'd0, bus.o_rd_we, bus.o_rd}, {27'd0, m_rd_we, m_rd});
    check("o_stall_cnt", {16'd0, bus.o_stall_cnt}, min_int(m_stalls, 65535));
    check("o_stall_cnt_sat", {28'd0, bus_s.o_stall_cnt}, min_int(m_stalls, 15));
  endtask

  // ---------------- stimulus ----------------
  int s0;

  initial begin
    i_rst = 1'b1;
    drive_idle();
    model_reset();
    @(negedge i_clk);
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_op0", bus.o_op0, 32'd0);
    check("rst_op1", bus.o_op1, 32'd0);
    check("rst_cnt", {16'd0, bus.o_stall_cnt}, 32'd0);
    drive_instr(4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 32'hAAAA5555, 32'h5555AAAA);
    #1;
    check("rst_ready", {31'd0, bus.o_ready}, 32'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    check("rst_no_accept", {31'd0, bus.o_valid}, 32'd0);
    i_rst = 1'b0;
    drive_idle();

    // Back-to-back independent instructions.
    drive_instr(4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 32'h11111111, 32'h22222222);
    tick();
    check("b2b_op0", bus.o_op0, 32'h11111111);
    drive_instr(4'd1, 1'b1, 4'd2, 1'b1, 4'd4, 1'b1, 32'h11111111, 32'h22222222);
    tick();
    check("b2b_valid", {31'd0, bus.o_valid}, 32'd1);
    check("b2b_rd", {28'd0, bus.o_rd}, 32'd4);
    check("b2b_cnt", {16'd0, bus.o_stall_cnt}, 32'd0);
    drive_idle(); bus.i_wb_valid = 1'b1; bus.i_wb_addr = 4'd3; tick();
    bus.i_wb_addr = 4'd4; tick();

    // RAW hazard resolved by write-back three cycles later.
    drive_idle();
    drive_instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 32'h0000000A, 32'h0000000B);
    tick();
    s0 = m_stalls;
    drive_instr(4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b0, 32'h00000055, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("raw_blocked", {31'd0, bus.o_ready}, 32'd0);
    end
    bus.i_wb_valid = 1'b1; bus.i_wb_addr = 4'd5;
    tick();
    check("raw_accept", bus.o_op0, 32'h00000055);
    check("raw_stalls", {16'd0, bus.o_stall_cnt}, s0 + 3);

    // Backpressure holds the bundle.
    drive_idle();
    drive_instr(4'd1, 1'b1, 4'd2, 1'b0, 4'd8, 1'b0, 32'hDEADBEEF, 32'h12345678);
    tick();
    drive_instr(4'd1, 1'b1, 4'd2, 1'b0, 4'd9, 1'b0, 32'hCAFEF00D, 32'h0);
    bus.i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold", bus.o_op0, 32'hDEADBEEF);
    end
    bus.i_ready = 1'b1;
    tick();
    check("bp_next", bus.o_op0, 32'hCAFEF00D);

    // Same-cycle set and clear of R7 keeps it pending.
    drive_idle();
    drive_instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 32'h7, 32'h7);
    bus.i_wb_valid = 1'b1; bus.i_wb_addr = 4'd7;
    tick();
    drive_idle();
    drive_instr(4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 32'h1, 32'h2);
    tick();
    check("setclr_stall", {31'd0, bus.o_ready}, 32'd0);
    bus.i_wb_valid = 1'b1; bus.i_wb_addr = 4'd7;
    tick();

    // Async reset in the middle of a stall.
    drive_idle();
    drive_instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 32'h5, 32'h5);
    tick();
    drive_instr(4'd5, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0, 32'h00000505, 32'h0);
    bus.i_ready = 1'b0;
    tick();
    #2 i_rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("arst_cnt", {16'd0, bus.o_stall_cnt}, 32'd0);
    check("arst_ready", {31'd0, bus.o_ready}, 32'd1);
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();
    check("arst_r5_accept", bus.o_op0, 32'h00000505);

    // Twenty forced stall cycles saturate the 4-bit counter.
    drive_idle();
    drive_instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 32'h9, 32'h9);
    tick();
    drive_instr(4'd0, 1'b0, 4'd9, 1'b1, 4'd0, 1'b0, 32'h1, 32'h1);
    for (int i = 0; i < 20; i++) tick();
    check("sat_cnt", {28'd0, bus_s.o_stall_cnt}, 32'd15);
    check("sat_wide_cnt", {16'd0, bus.o_stall_cnt}, 32'd20);
    drive_idle(); bus.i_wb_valid = 1'b1; bus.i_wb_addr = 4'd9; tick();

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      bus.i_clk_en   = ($urandom_range(0, 9) != 0);
      bus.i_valid    = ($urandom_range(0, 9) < 7);
      bus.i_ready    = ($urandom_range(0, 9) < 7);
      bus.i_rs0      = 4'($urandom_range(0, 15));
      bus.i_rs1      = 4'($urandom_range(0, 15));
      bus.i_use_rs0  = $urandom_range(0, 1) != 0;
      bus.i_use_rs1  = $urandom_range(0, 1) != 0;
      bus.i_rd       = 4'($urandom_range(0, 15));
      bus.i_rd_we    = ($urandom_range(0, 3) != 0);
      bus.i_rdata_0  = $urandom;
      bus.i_rdata_1  = $urandom;
      bus.i_wb_valid = ($urandom_range(0, 9) < 4);
      bus.i_wb_addr  = 4'($urandom_range(0, 15));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
